// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Run/pause/clear sequencer, tick prescaler, lap capture and
//                terminal-count handling for a 4-digit BCD stopwatch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int WRAP     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    input  logic [15:0] q,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic [15:0] lap_q,
    output logic        lap_valid,
    output logic        ovf,
    output logic [1:0]  state
);

    localparam int           c_DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(TICK_DIV - 1);
    localparam [c_DIV_W-1:0] c_DIV_ONE = c_DIV_W'(1);

    localparam [1:0] c_IDLE  = 2'b00;
    localparam [1:0] c_RUN   = 2'b01;
    localparam [1:0] c_PAUSE = 2'b10;
    localparam [1:0] c_HALT  = 2'b11;

    logic [1:0]         r_state,     w_state_nxt;
    logic [c_DIV_W-1:0] r_div,       w_div_nxt;
    logic               r_cnt_clr;
    logic [15:0]        r_lap_q,     w_lap_q_nxt;
    logic               r_lap_valid, w_lap_valid_nxt;
    logic               r_ovf,       w_ovf_nxt;

    logic w_due;
    logic w_term;
    logic w_block;

    // Strobe is decoded straight from registers so an async reset kills it at once.
    assign w_due   = (r_state == c_RUN) && (r_div == c_DIV_MAX);
    assign w_term  = (q == 16'h9999);
    assign w_block = w_due && w_term && (WRAP == 0);

    assign cnt_en    = w_due && !w_block;
    assign cnt_clr   = r_cnt_clr;
    assign lap_q     = r_lap_q;
    assign lap_valid = r_lap_valid;
    assign ovf       = r_ovf;
    assign state     = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_div       <= '0;
            r_cnt_clr   <= 1'b0;
            r_lap_q     <= 16'h0000;
            r_lap_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_cnt_clr   <= clear;
            r_lap_q     <= w_lap_q_nxt;
            r_lap_valid <= w_lap_valid_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_lap_q_nxt     = r_lap_q;
        w_lap_valid_nxt = r_lap_valid;
        w_ovf_nxt       = r_ovf;

        if (clear) begin
            w_state_nxt     = c_IDLE;
            w_div_nxt       = '0;
            w_lap_valid_nxt = 1'b0;
            w_ovf_nxt       = 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_stop) begin
                        w_state_nxt = c_RUN;
                        w_div_nxt   = '0;
                    end
                end
                c_RUN: begin
                    if (w_block) begin
                        w_state_nxt = c_HALT;
                        w_ovf_nxt   = 1'b1;
                        w_div_nxt   = '0;
                    end else begin
                        if (w_due && w_term)
                            w_ovf_nxt = 1'b1;
                        // Pausing freezes the partial tick so resume picks it up.
                        if (start_stop)
                            w_state_nxt = c_PAUSE;
                        else
                            w_div_nxt = w_due ? '0 : (r_div + c_DIV_ONE);
                    end
                end
                c_PAUSE: begin
                    if (start_stop)
                        w_state_nxt = c_RUN;
                end
                default: begin
                end
            endcase

            if (lap && !start_stop && (r_state != c_IDLE)) begin
                w_lap_q_nxt     = q;
                w_lap_valid_nxt = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed bench for stopwatch_ctrl with behavioural BCD counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic        clk;
    logic        reset;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic        r_load;
    logic [15:0] r_load_val;

    logic [15:0] q0, q1;
    logic        cnt_en0, cnt_clr0, lap_valid0, ovf0;
    logic        cnt_en1, cnt_clr1, lap_valid1, ovf1;
    logic [15:0] lap_q0, lap_q1;
    logic [1:0]  state0, state1;

    int n_checks;
    int n_fail;

    stopwatch_ctrl #(.TICK_DIV(4), .WRAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
        .q(q0), .cnt_en(cnt_en0), .cnt_clr(cnt_clr0), .lap_q(lap_q0),
        .lap_valid(lap_valid0), .ovf(ovf0), .state(state0)
    );

    stopwatch_ctrl #(.TICK_DIV(4), .WRAP(1)) u_dut1 (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
        .q(q1), .cnt_en(cnt_en1), .cnt_clr(cnt_clr1), .lap_q(lap_q1),
        .lap_valid(lap_valid1), .ovf(ovf1), .state(state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (c) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Behavioural BCD counters, one per controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q0 <= 16'h0000;
            q1 <= 16'h0000;
        end else begin
            if (r_load)        q0 <= r_load_val;
            else if (cnt_clr0) q0 <= 16'h0000;
            else if (cnt_en0)  q0 <= bcd_inc(q0);
            if (r_load)        q1 <= r_load_val;
            else if (cnt_clr1) q1 <= 16'h0000;
            else if (cnt_en1)  q1 <= bcd_inc(q1);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    task automatic preload(input logic [15:0] v);
        r_load     = 1'b1;
        r_load_val = v;
        step();
        r_load     = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        r_load     = 1'b0;
        r_load_val = 16'h0000;

        // Reset values
        #12;
        chk_eq("rst_state", 32'(state0), 32'h0);
        chk_eq("rst_cnt_en", 32'(cnt_en0), 32'h0);
        chk_eq("rst_cnt_clr", 32'(cnt_clr0), 32'h0);
        chk_eq("rst_lap_q", 32'(lap_q0), 32'h0);
        chk_eq("rst_lap_valid", 32'(lap_valid0), 32'h0);
        chk_eq("rst_ovf", 32'(ovf0), 32'h0);
        step();
        reset = 1'b0;
        step();

        // 1: start, strobes in RUN cycles 4, 8, 12
        pulse_ss();
        chk_eq("t1_state_run", 32'(state0), 32'h1);
        for (int i = 1; i <= 12; i++) begin
            chk_eq($sformatf("t1_cnt_en_c%0d", i), 32'(cnt_en0), 32'((i % 4) == 0));
            step();
        end
        chk_eq("t1_q", 32'(q0), 32'h0003);

        // 2: pause mid-tick and resume the partial tick
        do_clear();
        chk_eq("t2_q_cleared", 32'(q0), 32'h0000);
        pulse_ss();
        repeat (6) step();
        chk_eq("t2_q_before_pause", 32'(q0), 32'h0001);
        pulse_ss();
        chk_eq("t2_state_pause", 32'(state0), 32'h2);
        for (int i = 0; i < 20; i++) begin
            chk_eq("t2_pause_cnt_en", 32'(cnt_en0), 32'h0);
            step();
        end
        chk_eq("t2_q_paused", 32'(q0), 32'h0001);
        pulse_ss();
        chk_eq("t2_state_resume", 32'(state0), 32'h1);
        chk_eq("t2_resume_c1_en", 32'(cnt_en0), 32'h0);
        step();
        chk_eq("t2_resume_c2_en", 32'(cnt_en0), 32'h1);
        step();
        chk_eq("t2_q_after", 32'(q0), 32'h0002);

        // 3: halt at 9999
        do_clear();
        preload(16'h9998);
        pulse_ss();
        repeat (4) step();
        chk_eq("t3_q_9999", 32'(q0), 32'h9999);
        repeat (3) step();
        chk_eq("t3_blocked_en", 32'(cnt_en0), 32'h0);
        step();
        chk_eq("t3_state_halt", 32'(state0), 32'h3);
        chk_eq("t3_ovf", 32'(ovf0), 32'h1);
        chk_eq("t3_q_hold", 32'(q0), 32'h9999);
        pulse_ss();
        repeat (5) step();
        chk_eq("t3_state_still_halt", 32'(state0), 32'h3);
        chk_eq("t3_q_still", 32'(q0), 32'h9999);

        // 4: rollover with WRAP=1
        do_clear();
        chk_eq("t4_ovf_cleared", 32'(ovf1), 32'h0);
        preload(16'h9999);
        pulse_ss();
        repeat (3) step();
        chk_eq("t4_wrap_en", 32'(cnt_en1), 32'h1);
        step();
        chk_eq("t4_q_rolled", 32'(q1), 32'h0000);
        chk_eq("t4_ovf", 32'(ovf1), 32'h1);
        chk_eq("t4_state_run", 32'(state1), 32'h1);
        repeat (4) step();
        chk_eq("t4_q_next", 32'(q1), 32'h0001);
        chk_eq("t4_ovf_sticky", 32'(ovf1), 32'h1);

        // 5: lap in strobe cycle, then lap together with clear
        do_clear();
        preload(16'h0042);
        pulse_ss();
        repeat (3) step();
        chk_eq("t5_strobe", 32'(cnt_en0), 32'h1);
        lap = 1'b1;
        step();
        lap = 1'b0;
        chk_eq("t5_lap_q", 32'(lap_q0), 32'h0042);
        chk_eq("t5_lap_valid", 32'(lap_valid0), 32'h1);
        chk_eq("t5_q_inc", 32'(q0), 32'h0043);
        lap   = 1'b1;
        clear = 1'b1;
        step();
        lap   = 1'b0;
        clear = 1'b0;
        chk_eq("t5_cnt_clr", 32'(cnt_clr0), 32'h1);
        chk_eq("t5_state_idle", 32'(state0), 32'h0);
        chk_eq("t5_lap_valid_clr", 32'(lap_valid0), 32'h0);
        chk_eq("t5_lap_q_hold", 32'(lap_q0), 32'h0042);
        step();
        chk_eq("t5_cnt_clr_1cyc", 32'(cnt_clr0), 32'h0);
        chk_eq("t5_q_zero", 32'(q0), 32'h0000);

        // 6: async reset mid-RUN while div = 3
        pulse_ss();
        repeat (3) step();
        chk_eq("t6_pre_en", 32'(cnt_en0), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk_eq("t6_cnt_en_dropped", 32'(cnt_en0), 32'h0);
        chk_eq("t6_state", 32'(state0), 32'h0);
        chk_eq("t6_lap_q", 32'(lap_q0), 32'h0);
        chk_eq("t6_ovf1", 32'(ovf1), 32'h0);
        step();
        reset = 1'b0;
        step();
        lap = 1'b1;
        step();
        lap = 1'b0;
        chk_eq("t6_idle_lap_ignored", 32'(lap_valid0), 32'h0);
        chk_eq("t6_idle_lap_q", 32'(lap_q0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/clear controller for the 4-digit BCD counter datapath. It generates the counter's single-cycle increment strobe from a clock prescaler and sequences start, pause, resume and clear through an FSM. It also captures lap snapshots of the counter value and detects the 9999 terminal count. It sits between the user-pulse inputs and the BCD counter, whose value is fed back on `q`.

Parameters:
- `TICK_DIV`, default 4: clock cycles per count increment, legal range ≥ 2.
- `WRAP`, default 0: terminal-count policy.
  - 0 = halt at 9999.
  - 1 = roll over to 0000 and continue.

Ports:
- `clk`  input  1: system clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `start_stop`  input  1: one-cycle pulse that toggles run/pause.
- `clear`  input  1: one-cycle pulse that returns everything to zero/idle.
- `lap`  input  1: one-cycle pulse that captures the current count.
- `q`  input  16: BCD counter value; four nibbles, each 0–9; `q[15:12]` is the most significant digit.
- `cnt_en`  output  1: increment strobe to the counter; the counter advances on the edge where it is high.
- `cnt_clr`  output  1: synchronous clear strobe to the counter.
- `lap_q`  output  16: last captured count.
- `lap_valid`  output  1: sticky flag, `lap_q` holds a capture.
- `ovf`  output  1: sticky flag, terminal count reached.
- `state`  output  2: FSM state encoding.
  - IDLE = 00, RUN = 01, PAUSE = 10, HALT = 11.

Behaviour:
- Reset (async, immediate):
  - `state` = IDLE, prescaler `div` = 0.
  - `cnt_en` = 0, `cnt_clr` = 0.
  - `lap_q` = 16'h0000, `lap_valid` = 0, `ovf` = 0.
- Reset mid-RUN kills any pending `cnt_en` in the same cycle.
- Input priority per edge: `clear` > `start_stop` > `lap`.
  - `clear` with `lap` in the same cycle: the lap is ignored.
- `clear`, in any state:
  - `cnt_clr` = 1 for exactly the next cycle (registered).
  - `state` → IDLE, `div` → 0, `lap_valid` → 0, `ovf` → 0.
  - `lap_q` holds its value.
- FSM transitions, all on `start_stop`:
  - IDLE → RUN, with `div` → 0.
  - RUN → PAUSE, with `div` held.
  - PAUSE → RUN, resuming the partial tick with `div` unchanged.
  - HALT: `start_stop` is ignored; only `clear` exits.
- Prescaler:
  - Counts only in RUN, from 0 to `TICK_DIV`−1, then wraps to 0.
  - Frozen in every other state.
- Increment strobe:
  - `cnt_en` = (`state` == RUN) && (`div` == `TICK_DIV`−1) && !`block`.
  - Combinational from registers; no registered latency.
  - Result: one strobe every `TICK_DIV` RUN cycles. The first strobe is in the `TICK_DIV`-th RUN cycle after the IDLE→RUN edge.
  - A `start_stop` pulse sampled in the same cycle as a strobe: the strobe is still issued, then the FSM pauses.
- Terminal count, when `q` == 16'h9999 and a strobe is due:
  - `WRAP` = 0: `block` = 1, so `cnt_en` is suppressed; `state` → HALT, `ovf` → 1.
  - `WRAP` = 1: `cnt_en` is issued, so the counter rolls to 0000; `ovf` → 1 (sticky) and the FSM stays in RUN.
- Lap:
  - In RUN, PAUSE or HALT, a `lap` pulse loads `lap_q` ← `q` on that edge and sets `lap_valid` = 1.
  - `lap` is ignored in IDLE.
  - A new lap overwrites `lap_q`.
  - A lap sampled in the same cycle as a strobe captures the pre-increment `q`.
- `q` is trusted to be valid BCD; the controller does no digit checking.

Test Plan:
All scenarios use a behavioural BCD counter model driven by `cnt_en`/`cnt_clr`, `TICK_DIV` = 4 unless noted.
1. Reset, then `start_stop` pulse → `state` = 01; `cnt_en` high in RUN cycles 4, 8, 12; `q` = 0003 after 12 RUN cycles.
2. Run for 6 cycles (`q` = 0001, `div` = 2), `start_stop` → PAUSE, wait 20 cycles (`q` stays 0001, no `cnt_en`), `start_stop` again → next strobe after 2 RUN cycles (not 4), then `q` = 0002.
3. `WRAP` = 0, preload model to 9998, run → `q` reaches 9999; the next due strobe is suppressed, `state` = 11, `ovf` = 1; a further `start_stop` leaves `state` = 11 and `q` = 9999.
4. `WRAP` = 1, preload 9999, run → strobe issued, `q` = 0000, `ovf` = 1, `state` stays 01, counting continues to 0001.
5. At `q` = 0042 in RUN, pulse `lap` in a strobe cycle → `lap_q` = 0042, `lap_valid` = 1, `q` = 0043. Then pulse `lap` and `clear` together → `cnt_clr` high for 1 cycle, `q` = 0000, `state` = 00, `lap_valid` = 0, `lap_q` still 0042.
6. Assert `reset` asynchronously mid-RUN when `div` = 3 → `cnt_en` drops immediately, all outputs reach reset values before the next edge; `lap` pulsed in IDLE → `lap_valid` stays 0.
